// File: rtl/alu_bist_pkg.sv
// ---------------------------------------------------------------------------
// alu_bist_pkg
// Shared definitions for the ALU built-in self-test engine: controller state
// encoding, ALU opcode values, the MISR feedback polynomial and the LFSR tap
// positions. The counter width follows the build configuration.
//
// Configuration macro: ALU_BIST_EXHAUSTIVE_EN
//   defined   -> exhaustive sweep of all 1024 vectors, 11-bit vector count
//   undefined -> pseudo-random LFSR stimulus, 10-bit vector count
// ---------------------------------------------------------------------------
package alu_bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } bist_state_e;

   // ALU opcode values as seen on alu_op.
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // CRC-16-CCITT style feedback polynomial for the signature register.
   localparam logic [15:0] MISR_POLY = 16'h1021;

   // Feedback taps of the 10-bit maximal-length LFSR (x^10 + x^7 + 1).
   localparam int LFSR_TAP_HI = 9;
   localparam int LFSR_TAP_LO = 6;

   // Stimulus register value after reset and substitute for a zero seed.
   localparam logic [9:0] LFSR_RESET = 10'h001;

`ifdef ALU_BIST_EXHAUSTIVE_EN
   localparam int VEC_CNT_W = 11;
`else
   localparam int VEC_CNT_W = 10;
`endif

endpackage

// File: rtl/alu_bist_misr.sv
// ---------------------------------------------------------------------------
// alu_bist_misr
// 16-bit multiple-input signature register with a 4-bit data input. Each
// enabled cycle the register shifts left, folds the polynomial back in when
// the outgoing bit is set, and XORs the new data into the low nibble.
// Written as a standalone block so other DFT engines can reuse it.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset (signature -> 0)
//   i_clear   synchronous clear (signature -> 0), wins over enable
//   i_enable  compact i_data into the signature this cycle
//   i_data    4-bit response to compact
//   o_sig     current signature
// ---------------------------------------------------------------------------
module alu_bist_misr
   import alu_bist_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_enable,
   input  logic [3:0]  i_data,
   output logic [15:0] o_sig
);

   logic [15:0] r_sig;
   logic [15:0] w_shifted;

   // Galois-style shift: the bit falling off the top decides whether the
   // polynomial is folded back into the shifted value.
   assign w_shifted = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000);

   // Signature register: reset and clear both return it to zero so a new
   // run always starts from a known state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sig <= 16'h0000;
      end else if (i_clear) begin
         r_sig <= 16'h0000;
      end else if (i_enable) begin
         r_sig <= w_shifted ^ {12'h000, i_data};
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// alu_bist_ctrl
// BIST engine for the 4-bit combinational ALU. On start it walks a stimulus
// register through NUM_PATTERNS states, drives {A, B, Op} straight from it,
// compacts the returned ALU result into a MISR, then compares the final
// signature with GOLDEN_SIG and pulses done for one cycle.
//
// Parameters:
//   NUM_PATTERNS  vectors per run (1..1023)
//   LFSR_SEED     initial LFSR state, zero is replaced by 10'h001
//   GOLDEN_SIG    expected final signature
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset, aborts any run
//   i_start      level start request, only looked at in IDLE
//   i_alu_c      ALU result for the vector currently presented
//   o_alu_a      operand A  = stimulus[9:6]
//   o_alu_b      operand B  = stimulus[5:2]
//   o_alu_op     opcode     = stimulus[1:0]
//   o_busy       high while running or comparing
//   o_done       one-cycle completion pulse
//   o_pass       result of the last completed run
//   o_signature  MISR contents
//   o_vec_count  vectors applied in the current run
//
// Configuration macro: ALU_BIST_EXHAUSTIVE_EN
//   defined   -> stimulus is a binary up-counter from 0, run length 1024,
//                NUM_PATTERNS and LFSR_SEED are ignored
//   undefined -> pseudo-random LFSR stimulus
// ---------------------------------------------------------------------------
module alu_bist_ctrl
   import alu_bist_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS = 64,
   parameter logic [9:0]  LFSR_SEED    = 10'h001,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [3:0]           i_alu_c,
   output logic [3:0]           o_alu_a,
   output logic [3:0]           o_alu_b,
   output logic [1:0]           o_alu_op,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [15:0]          o_signature,
   output logic [VEC_CNT_W-1:0] o_vec_count
);

`ifdef ALU_BIST_EXHAUSTIVE_EN
   localparam logic [9:0]           START_VEC = 10'h000;
   localparam logic [VEC_CNT_W-1:0] LAST_VEC  = VEC_CNT_W'(1023);
`else
   localparam logic [9:0]           START_VEC = (LFSR_SEED == 10'h000) ? LFSR_RESET : LFSR_SEED;
   localparam logic [VEC_CNT_W-1:0] LAST_VEC  = VEC_CNT_W'(NUM_PATTERNS - 1);
`endif

   bist_state_e            r_state;
   bist_state_e            w_nextState;
   logic [9:0]             r_lfsr;
   logic [9:0]             w_lfsrNext;
   logic [VEC_CNT_W-1:0]   r_vecCount;
   logic                   r_pass;
   logic                   w_lastVec;
   logic                   w_load;
   logic                   w_step;
   logic                   w_compare;
   logic                   w_busy;
   logic                   w_done;
   logic [15:0]            w_sig;

   // Next stimulus value: either the next LFSR state or the next count
   // in the exhaustive sweep.
`ifdef ALU_BIST_EXHAUSTIVE_EN
   assign w_lfsrNext = r_lfsr + 10'd1;
`else
   assign w_lfsrNext = {r_lfsr[8:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
`endif

   // The vector presented in this RUN cycle is the final one of the run.
   assign w_lastVec = (r_vecCount == LAST_VEC);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and control decode. start is only honoured in IDLE, so a
   // request arriving mid-run never disturbs the run length, while a start
   // level still present after DONE launches the next run from IDLE.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_compare   = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_load      = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            w_step = 1'b1;
            if (w_lastVec) begin
               w_nextState = COMPARE;
            end
         end
         COMPARE: begin
            w_busy      = 1'b1;
            w_compare   = 1'b1;
            w_nextState = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Stimulus register, vector counter and pass flag. The stimulus does not
   // advance on the final RUN edge so the last applied vector stays on the
   // ALU ports while the engine compares and reports.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr     <= LFSR_RESET;
         r_vecCount <= '0;
         r_pass     <= 1'b0;
      end else begin
         if (w_load) begin
            r_lfsr     <= START_VEC;
            r_vecCount <= '0;
            r_pass     <= 1'b0;
         end else if (w_step) begin
            r_vecCount <= r_vecCount + 1'b1;
            if (!w_lastVec) begin
               r_lfsr <= w_lfsrNext;
            end
         end
         if (w_compare) begin
            r_pass <= (w_sig == GOLDEN_SIG);
         end
      end
   end

   alu_bist_misr u_misr (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_load),
      .i_enable (w_step),
      .i_data   (i_alu_c),
      .o_sig    (w_sig)
   );

   assign o_alu_a     = r_lfsr[9:6];
   assign o_alu_b     = r_lfsr[5:2];
   assign o_alu_op    = r_lfsr[1:0];
   assign o_busy      = w_busy;
   assign o_done      = w_done;
   assign o_pass      = r_pass;
   assign o_signature = w_sig;
   assign o_vec_count = r_vecCount;

endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

On-chip built-in self-test (BIST) engine for the 4-bit ALU (ops: Add 2'b00, Sub 2'b01, Mul 2'b10, Div 2'b11). It generates pseudo-random {A, B, Op} stimulus, drives the combinational ALU directly, and compacts the ALU result C into a 16-bit MISR signature. It compares that signature against a golden value and reports pass/fail. It sits beside the ALU, behind a start/done handshake from the DFT test controller.

## Interface
- NUM_PATTERNS, 64: number of vectors applied per run, 1..1023.
- LFSR_SEED, 10'h001: initial LFSR state. A value of 0 is replaced by 10'h001.
- GOLDEN_SIG, 16'h0000: expected final MISR signature.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE.
- alu_c  input  4  ALU result C, combinational from alu_a/alu_b/alu_op.
- alu_a  output  4  operand A = lfsr[9:6].
- alu_b  output  4  operand B = lfsr[5:2].
- alu_op  output  2  opcode = lfsr[1:0].
- busy  output  1  high in RUN and COMPARE.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  result of the last completed run; held until the next start.
- signature  output  16  MISR contents; live during RUN, frozen afterwards.
- vec_count  output  10  vectors applied so far in the current run.

## Operation
- FSM states: IDLE → RUN → COMPARE → DONE → IDLE.
- IDLE
  - busy=0.
  - On start=1: load the LFSR with the seed (0 is mapped to 1), clear the MISR and vec_count, clear pass, go to RUN.
- RUN: each cycle
  - alu_a/b/op are driven from the current LFSR state.
  - At the edge: MISR ← ({misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0)) ^ {12'h000, alu_c}.
  - LFSR ← {lfsr[8:0], lfsr[9]^lfsr[6]} (maximal length, period 1023).
  - vec_count increments.
  - When vec_count reaches NUM_PATTERNS-1 at that edge, go to COMPARE.
- COMPARE: pass ← (misr == GOLDEN_SIG). MISR and LFSR hold.
- DONE: done=1 for one cycle, then IDLE. pass, signature and vec_count hold until the next start.
- start outside IDLE is ignored.
- start still high on return to IDLE begins a new run (level semantics).
- Outputs in IDLE/COMPARE/DONE: alu_a/b/op hold the last applied vector. The ALU output is not sampled.

## Timing
- Reset values: state=IDLE, lfsr=10'h001 (alu_a=0, alu_b=0, alu_op=2'b01), misr=0, signature=0, vec_count=0, busy=0, done=0, pass=0.
- start sampled high at edge k:
  - first vector is presented in cycle k+1.
  - last vector is presented in cycle k+NUM_PATTERNS.
  - COMPARE occupies cycle k+NUM_PATTERNS+1.
  - done is high in cycle k+NUM_PATTERNS+2.
- Total latency from start to done: NUM_PATTERNS+2 cycles.
- The ALU is combinational. alu_c must settle within the same cycle the vector is presented; the MISR captures it at that cycle's closing edge.
- rst mid-run aborts immediately to reset values. No done pulse is produced and pass=0.
- rst and start high together: rst wins.

## Configuration
- ALU_BIST_EXHAUSTIVE_EN defined:
  - The LFSR is replaced by a 10-bit binary up-counter starting at 0.
  - All 1024 {A,B,Op} combinations are applied, including the all-zero vector.
  - NUM_PATTERNS and LFSR_SEED are ignored; the run length is fixed at 1024 and vec_count widens to 11 bits.
- Undefined: pseudo-random LFSR mode as described above.

## Structure
- Shared package alu_bist_pkg holds:
  - the state enum (IDLE, RUN, COMPARE, DONE)
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - MISR_POLY=16'h1021
  - the LFSR tap positions
- One sub-module, alu_bist_misr: 16-bit MISR with clear, enable and 4-bit data input, reused later for other DFT blocks.
- The FSM, LFSR and counter stay in alu_bist_ctrl.

## Test plan
- Reset only → all outputs at the reset values above; alu_op=2'b01.
- NUM_PATTERNS=4, seed 10'h001, start pulse at edge k → vectors presented:
  - lfsr 0x001 (Op=01)
  - lfsr 0x002 (Op=10)
  - lfsr 0x004 (B=1, Op=00)
  - lfsr 0x008 (B=2, Op=00)
  - then done high in cycle k+6 and vec_count=4.
- NUM_PATTERNS=2, alu_c forced to 4'h1 → signature=16'h0003. With GOLDEN_SIG=16'h0003, pass=1; with 16'h0000, pass=0.
- Real ALU connected, NUM_PATTERNS=64, GOLDEN_SIG taken from the reference model → pass=1. Inject a stuck-at-0 on alu_c[0] → pass=0.
- rst asserted at the 10th RUN cycle → next cycle in IDLE, busy=0, signature=0, no done pulse. A new start then completes normally.
- Start held high through DONE → a second run begins the cycle after DONE. A start pulse during RUN has no effect on run length.
